bus_interconnect_n: RTL and testbench
=====================================

Name: bus_interconnect_n

Overview:
Parametrised N-slave successor to the two-way RAM/GPIO bus interconnect. Decodes one master request onto one of N_SLAVES slave ports using an address-region field. Runs a registered request/ack handshake with a per-transaction timeout, and returns registered read data or an error to the core's load/store unit. Sits between the core data port and RAM, GPIO and future peripherals.

Parameters:
WIDTH, 32, data and address width
N_SLAVES, 4, number of slave ports (1..2**(SEL_MSB-SEL_LSB+1))
SEL_MSB, 31, MSB of the region-select field in the address
SEL_LSB, 28, LSB of the region-select field; default map: region 0 = RAM at 0x0000_0000, region 2 = GPIO at 0x2000_0000
TIMEOUT, 15, WAIT cycles before an error response; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
m_req  in  1  master request, sampled only in IDLE
m_we  in  1  1 = write, 0 = read
m_addr  in  WIDTH  request address
m_wdata  in  WIDTH  write data
m_ready  out  1  one-cycle response strobe
m_rdata  out  WIDTH  read data, valid while m_ready=1
m_err  out  1  error flag, valid while m_ready=1
busy  out  1  1 whenever the FSM is not in IDLE
s_sel  out  N_SLAVES  one-hot slave select
s_we  out  N_SLAVES  one-hot write enable; only asserted together with the matching s_sel bit
s_addr  out  WIDTH  latched address, broadcast to all slaves
s_wdata  out  WIDTH  latched write data, broadcast to all slaves
s_rdata  in  N_SLAVES*WIDTH  flattened slave read data; slave i occupies bits [i*WIDTH +: WIDTH]
s_ack  in  N_SLAVES  slave completion, one bit per slave
err_cnt  out  8  count of error responses, saturating

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE. Every output is 0, including s_sel, s_we, s_addr, s_wdata, m_rdata and err_cnt. Asserting reset mid-transaction drops s_sel/s_we immediately; the pending transaction is lost and gets no response.
- FSM states: IDLE, WAIT, RESP.
- IDLE, m_req=1 at an edge:
  - Latch addr, we and wdata.
  - idx = m_addr[SEL_MSB:SEL_LSB].
  - idx < N_SLAVES: go to WAIT with s_sel[idx]=1 and s_we[idx]=m_we; clear the timeout counter.
  - idx >= N_SLAVES (unmapped): go straight to RESP with err=1 and rdata=0. No slave is selected.
- IDLE, m_req=0: stay in IDLE. m_req is ignored in WAIT and RESP, and no requests are queued.
- WAIT: s_sel and s_we stay stable, s_addr and s_wdata stay stable.
  - s_ack[idx]=1 at an edge: capture s_rdata slice idx into m_rdata, or 0 for a write; err=0; go to RESP; deassert sel/we.
  - Otherwise, with TIMEOUT>0, the counter increments each cycle. If the counter reaches TIMEOUT-1 with no ack, go to RESP with err=1, rdata=0.
  - Ack and timeout in the same cycle: ack wins.
  - s_ack bits other than idx are ignored at all times, in every state.
- RESP: m_ready=1 for exactly one cycle, carrying the registered m_rdata and m_err. Next state is IDLE. If m_err=1, err_cnt increments, saturating at 255.
- m_rdata and m_err are 0 in every cycle where m_ready=0.
- Latency:
  - Mapped slave acking in its first WAIT cycle: request edge E, sel high after E, m_ready high after E+2.
  - Unmapped address: m_ready high after E+1.
  - Timeout: m_ready high after E+1+TIMEOUT.
- Minimum spacing between accepted requests is 3 cycles for a mapped slave, 2 for an unmapped address. busy=0 only in IDLE.
- Counter width is $clog2(TIMEOUT+1). Slave data is selected with an indexed part-select on idx latched in a register, never on the live m_addr.

Decomposition:
- Package bus_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} bus_state_t;
  - localparams for the default region indices (REGION_RAM=0, REGION_GPIO=2).
  - Function region_idx(addr) returning the select field.
- One sub-module, bus_decoder: combinational. Takes addr and returns the one-hot select plus a mapped flag. It is parametrised on N_SLAVES, SEL_MSB and SEL_LSB and is reusable by the instruction-side bus.

Test Plan:
- Reset mid-WAIT: read to 0x0000_0010, then rst_n=0 one cycle later -> s_sel=0 at once, all outputs 0, no m_ready, IDLE after release.
- Read from RAM: m_req=1, m_we=0, m_addr=0x0000_0010; slave 0 acks after 1 cycle with 0x0000_0400 -> s_sel=4'b0001, m_ready after E+2, m_rdata=0x400, m_err=0.
- Write to GPIO: m_we=1, m_addr=0x2000_0000, wdata=0xC; slave 2 acks after 3 cycles -> s_we=4'b0100 and s_wdata=0xC held, m_ready after E+4, m_rdata=0.
- Unmapped with N_SLAVES=3: m_addr=0x3000_0000 -> no s_sel, m_ready after E+1, m_err=1, err_cnt=1.
- Timeout: slave 1 never acks, TIMEOUT=15 -> m_err=1 at E+16; s_ack[0]=1 during the wait is ignored. A second run with ack and timeout in the same cycle -> m_err=0.
- Saturation and back-pressure: 300 unmapped requests -> err_cnt=255. m_req held high through WAIT -> only one transaction, new acceptance in the cycle after m_ready.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and helpers for the data-side bus interconnect.
//               - bus_state_t : transaction FSM state encoding
//               - REGION_*    : default region indices of the memory map
//               - region_idx  : extracts the region-select field of an address
// Revision    : 1.0 - initial N-slave release
// ============================================================================
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_state_t;

    // Default map: RAM at 0x0000_0000, GPIO at 0x2000_0000
    localparam int REGION_RAM  = 0;
    localparam int REGION_GPIO = 2;

    // Returns addr[msb:lsb] right-aligned. Bounds are run-time arguments so the
    // same helper serves any field position and address width up to 64 bits.
    function automatic logic [31:0] region_idx(input logic [63:0] addr,
                                               input int          msb,
                                               input int          lsb);
        logic [63:0] mask;
        mask = (64'd1 << (msb - lsb + 1)) - 64'd1;
        return 32'((addr >> lsb) & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bus_decoder
// Description : Combinational address-region decoder. Produces a one-hot slave
//               select from addr[SEL_MSB:SEL_LSB] and flags whether the region
//               is backed by a slave port.
// Ports       : i_addr   - address to decode
//               o_sel    - one-hot select (all zero when unmapped)
//               o_mapped - 1 when the region index is below N_SLAVES
// Revision    : 1.0 - initial release
// ============================================================================
module bus_decoder
    import bus_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_SLAVES = 4,
    parameter int SEL_MSB  = 31,
    parameter int SEL_LSB  = 28
) (
    input  logic [WIDTH-1:0]    i_addr,
    output logic [N_SLAVES-1:0] o_sel,
    output logic                o_mapped
);

    logic [31:0] w_idx;

    assign w_idx    = region_idx(64'(i_addr), SEL_MSB, SEL_LSB);
    assign o_mapped = (w_idx < 32'(N_SLAVES));

    generate
        for (genvar i = 0; i < N_SLAVES; i++) begin : g_sel
            assign o_sel[i] = (w_idx == 32'(i));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bus_interconnect_n.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bus_interconnect_n
// Description : Single-master, N-slave data bus interconnect. Routes one
//               request at a time to the slave chosen by the address region,
//               waits for that slave's ack (with optional timeout), and returns
//               a one-cycle registered response to the load/store unit.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               m_req/m_we/m_addr/m_wdata   - master request
//               m_ready/m_rdata/m_err       - master response strobe + payload
//               busy                        - FSM not in IDLE
//               s_sel/s_we/s_addr/s_wdata   - slave request (one-hot select)
//               s_rdata/s_ack               - slave responses, flattened
//               err_cnt                     - saturating error-response count
// Revision    : 1.0 - initial N-slave release
// ============================================================================
module bus_interconnect_n
    import bus_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_SLAVES = 4,
    parameter int SEL_MSB  = 31,
    parameter int SEL_LSB  = 28,
    parameter int TIMEOUT  = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      m_req,
    input  logic                      m_we,
    input  logic [WIDTH-1:0]          m_addr,
    input  logic [WIDTH-1:0]          m_wdata,
    output logic                      m_ready,
    output logic [WIDTH-1:0]          m_rdata,
    output logic                      m_err,
    output logic                      busy,
    output logic [N_SLAVES-1:0]       s_sel,
    output logic [N_SLAVES-1:0]       s_we,
    output logic [WIDTH-1:0]          s_addr,
    output logic [WIDTH-1:0]          s_wdata,
    input  logic [N_SLAVES*WIDTH-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]       s_ack,
    output logic [7:0]                err_cnt
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    // A zero TIMEOUT still gets a 1-bit counter; it simply never fires.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [7:0]       c_ERR_MAX  = 8'hFF;

    bus_state_t          r_state;
    bus_state_t          w_state_nxt;

    logic [N_SLAVES-1:0] w_sel;
    logic                w_mapped;
    logic [IDX_W-1:0]    w_idx;
    logic                w_ack;
    logic                w_timeout;

    logic [IDX_W-1:0]    r_idx;
    logic [N_SLAVES-1:0] r_sel;
    logic [N_SLAVES-1:0] r_we;
    logic                r_wr;
    logic [WIDTH-1:0]    r_addr;
    logic [WIDTH-1:0]    r_wdata;
    logic [WIDTH-1:0]    r_rdata;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;
    logic [7:0]          r_err_cnt;

    bus_decoder #(
        .WIDTH    (WIDTH),
        .N_SLAVES (N_SLAVES),
        .SEL_MSB  (SEL_MSB),
        .SEL_LSB  (SEL_LSB)
    ) u_decoder (
        .i_addr   (m_addr),
        .o_sel    (w_sel),
        .o_mapped (w_mapped)
    );

    // One-hot to binary; only meaningful when w_mapped is set.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (w_sel[i]) w_idx = IDX_W'(i);
        end
    end

    // Only the ack of the latched target counts; other slaves are ignored.
    assign w_ack     = s_ack[r_idx];
    assign w_timeout = (TIMEOUT > 0) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        m_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (m_req) w_state_nxt = w_mapped ? WAIT : RESP;
            end
            WAIT: begin
                if (w_ack || w_timeout) w_state_nxt = RESP;
            end
            RESP: begin
                m_ready     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Response payload is loaded only on entry to RESP and cleared on exit,
    // so m_rdata/m_err read as zero whenever m_ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_sel     <= '0;
            r_we      <= '0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m_req) begin
                        r_addr  <= m_addr;
                        r_wdata <= m_wdata;
                        r_wr    <= m_we;
                        r_idx   <= w_idx;
                        r_cnt   <= '0;
                        if (w_mapped) begin
                            r_sel <= w_sel;
                            r_we  <= m_we ? w_sel : '0;
                        end else begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (w_ack) begin
                        r_rdata <= r_wr ? '0 : s_rdata[r_idx*WIDTH +: WIDTH];
                        r_err   <= 1'b0;
                        r_sel   <= '0;
                        r_we    <= '0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_sel   <= '0;
                        r_we    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    if (r_err && (r_err_cnt != c_ERR_MAX)) r_err_cnt <= r_err_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign m_rdata = r_rdata;
    assign m_err   = r_err;
    assign s_sel   = r_sel;
    assign s_we    = r_we;
    assign s_addr  = r_addr;
    assign s_wdata = r_wdata;
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bus_interconnect_n.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bus_interconnect_n
// Description : Directed self-checking bench for bus_interconnect_n with three
//               slave ports (region 3 unmapped) and a 15-cycle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_interconnect_n;
    import bus_pkg::*;

    localparam int WIDTH    = 32;
    localparam int N_SLAVES = 3;
    localparam int TIMEOUT  = 15;

    localparam logic [31:0] A_RAM   = (32'(REGION_RAM) << 28) | 32'h10;
    localparam logic [31:0] A_GPIO  = 32'(REGION_GPIO) << 28;
    localparam logic [31:0] A_SLV1  = 32'h1000_0000;
    localparam logic [31:0] A_UNMAP = 32'h3000_0000;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      m_req;
    logic                      m_we;
    logic [WIDTH-1:0]          m_addr;
    logic [WIDTH-1:0]          m_wdata;
    logic                      m_ready;
    logic [WIDTH-1:0]          m_rdata;
    logic                      m_err;
    logic                      busy;
    logic [N_SLAVES-1:0]       s_sel;
    logic [N_SLAVES-1:0]       s_we;
    logic [WIDTH-1:0]          s_addr;
    logic [WIDTH-1:0]          s_wdata;
    logic [N_SLAVES*WIDTH-1:0] s_rdata;
    logic [N_SLAVES-1:0]       s_ack;
    logic [7:0]                err_cnt;

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    bus_interconnect_n #(
        .WIDTH    (WIDTH),
        .N_SLAVES (N_SLAVES),
        .SEL_MSB  (31),
        .SEL_LSB  (28),
        .TIMEOUT  (TIMEOUT)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .m_err   (m_err),
        .busy    (busy),
        .s_sel   (s_sel),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ack   (s_ack),
        .err_cnt (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        s_rdata = '0;
        s_ack   = '0;
        step();
        step();
        check("rst_sel",     32'(s_sel),   32'h0);
        check("rst_ready",   32'(m_ready), 32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        check("rst_errcnt",  32'(err_cnt), 32'h0);
        check("rst_rdata",   m_rdata,      32'h0);
        rst_n = 1'b1;
        step();

        // ---- reset mid-WAIT ----
        m_req = 1'b1; m_we = 1'b0; m_addr = A_RAM;
        step();                                   // edge E
        m_req = 1'b0;
        check("rw_sel",   32'(s_sel),  32'h1);
        check("rw_addr",  s_addr,      A_RAM);
        step();                                   // still waiting
        rst_n = 1'b0;
        #1;
        check("rw_sel_drop", 32'(s_sel),   32'h0);
        check("rw_addr_clr", s_addr,       32'h0);
        check("rw_busy",     32'(busy),    32'h0);
        check("rw_ready",    32'(m_ready), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("rw_idle_ready", 32'(m_ready), 32'h0);
        check("rw_idle_busy",  32'(busy),    32'h0);

        // ---- read from RAM, ack sampled at E+1, m_ready seen at E+2 ----
        s_rdata[0 +: WIDTH] = 32'h0000_0400;
        m_req = 1'b1; m_we = 1'b0; m_addr = A_RAM;
        step();                                   // E
        m_req = 1'b0;
        check("rd_sel",   32'(s_sel),   32'h1);
        check("rd_we",    32'(s_we),    32'h0);
        check("rd_ready0", 32'(m_ready), 32'h0);
        s_ack = 3'b001;
        step();                                   // E+1
        s_ack = '0;
        check("rd_ready",  32'(m_ready), 32'h1);
        check("rd_rdata",  m_rdata,      32'h0000_0400);
        check("rd_err",    32'(m_err),   32'h0);
        check("rd_seloff", 32'(s_sel),   32'h0);
        step();
        check("rd_ready_off", 32'(m_ready), 32'h0);
        check("rd_rdata_off", m_rdata,      32'h0);
        check("rd_busy_off",  32'(busy),    32'h0);

        // ---- write to GPIO, ack sampled at E+3 ----
        s_rdata[2*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        m_req = 1'b1; m_we = 1'b1; m_addr = A_GPIO; m_wdata = 32'hC;
        step();                                   // E
        m_req = 1'b0; m_we = 1'b0; m_wdata = '0;
        for (int k = 0; k < 3; k++) begin
            check("wr_sel",   32'(s_sel),   32'h4);
            check("wr_we",    32'(s_we),    32'h4);
            check("wr_wdata", s_wdata,      32'hC);
            check("wr_noready", 32'(m_ready), 32'h0);
            if (k == 2) s_ack = 3'b100;
            step();
        end
        s_ack = '0;
        check("wr_ready", 32'(m_ready), 32'h1);
        check("wr_rdata", m_rdata,      32'h0);
        check("wr_err",   32'(m_err),   32'h0);
        check("wr_weoff", 32'(s_we),    32'h0);
        step();

        // ---- unmapped region 3 ----
        m_req = 1'b1; m_addr = A_UNMAP;
        step();                                   // E
        m_req = 1'b0;
        check("um_sel",    32'(s_sel),   32'h0);
        check("um_ready",  32'(m_ready), 32'h1);
        check("um_err",    32'(m_err),   32'h1);
        check("um_rdata",  m_rdata,      32'h0);
        step();
        check("um_ready_off", 32'(m_ready), 32'h0);
        check("um_err_off",   32'(m_err),   32'h0);
        check("um_errcnt",    32'(err_cnt), 32'h1);

        // ---- timeout on slave 1; stray ack from slave 0 ignored ----
        s_rdata[0 +: WIDTH] = 32'h1111_1111;
        m_req = 1'b1; m_addr = A_SLV1;
        step();                                   // E
        m_req = 1'b0;
        check("to_sel", 32'(s_sel), 32'h2);
        s_ack = 3'b001;
        for (int k = 1; k < TIMEOUT; k++) begin
            step();
            check("to_wait", 32'(m_ready), 32'h0);
        end
        step();                                   // E+15, seen at E+16
        s_ack = '0;
        check("to_ready", 32'(m_ready), 32'h1);
        check("to_err",   32'(m_err),   32'h1);
        check("to_rdata", m_rdata,      32'h0);
        step();
        check("to_errcnt", 32'(err_cnt), 32'h2);

        // ---- ack arriving on the timeout cycle wins ----
        s_rdata[1*WIDTH +: WIDTH] = 32'h0000_1234;
        m_req = 1'b1; m_addr = A_SLV1;
        step();
        m_req = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) step();
        s_ack = 3'b010;
        step();
        s_ack = '0;
        check("ta_ready", 32'(m_ready), 32'h1);
        check("ta_err",   32'(m_err),   32'h0);
        check("ta_rdata", m_rdata,      32'h0000_1234);
        step();
        check("ta_errcnt", 32'(err_cnt), 32'h2);

        // ---- m_req held high: one transaction, next accepted after m_ready ----
        s_rdata[0 +: WIDTH] = 32'h55;
        s_ack = 3'b001;
        m_req = 1'b1; m_addr = A_RAM; m_we = 1'b0;
        step();                                   // E
        check("bp_busy",  32'(busy),    32'h1);
        step();                                   // E+1
        check("bp_ready", 32'(m_ready), 32'h1);
        check("bp_rdata", m_rdata,      32'h55);
        step();                                   // E+2
        check("bp_idle",    32'(busy),    32'h0);
        check("bp_noready", 32'(m_ready), 32'h0);
        check("bp_nosel",   32'(s_sel),   32'h0);
        step();                                   // E+3 accepts again
        check("bp_reaccept", 32'(s_sel), 32'h1);
        m_req = 1'b0;
        step();
        s_ack = '0;
        step();

        // ---- saturation: 300 back-to-back unmapped requests ----
        pulses = 0;
        m_req = 1'b1; m_addr = A_UNMAP;
        for (int k = 0; k < 600; k++) begin
            step();
            if (m_ready && m_err) pulses++;
        end
        m_req = 1'b0;
        step();
        step();
        check("sat_pulses", 32'(pulses),  32'd300);
        check("sat_errcnt", 32'(err_cnt), 32'd255);
        check("sat_idle",   32'(busy),    32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
